sensor_frame_parser: RTL

Byte-level frame parser for the wireless inertial sensor link, in the `clk_uart` domain. It sits between the UART byte receiver and `motion_detector` inside the sensor path. It reassembles 11-byte sensor frames, verifies each checksum and extracts one acceleration axis and one angle axis into registered outputs. It also reports framing errors and link liveness, so the game can fall back to button control when the link drops.

---
 rtl/sensor_frame_parser_pkg.sv | 26 ++
 rtl/sensor_frame_parser_if.sv | 10 +
 rtl/sensor_frame_parser_gap_timer.sv | 39 +++
 rtl/sensor_frame_parser.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sensor_frame_parser_pkg.sv
// Shared constants, types and helpers for the sensor frame parser.
package sensor_pkg;

  localparam logic [7:0] FRAME_HEADER  = 8'h55;
  localparam logic [7:0] TYPE_ACCEL    = 8'h51;
  localparam logic [7:0] TYPE_ANGLE    = 8'h53;
  localparam int         PAYLOAD_BYTES = 8;

  typedef enum logic [1:0] {
    HUNT,
    TYPE,
    PAYLOAD,
    CHECK
  } parser_state_t;

  // Payload buffer: byte 0 is the first byte after the type byte.
  typedef logic [PAYLOAD_BYTES-1:0][7:0] payload_t;

  // Reassemble a little-endian int16 word (axis 0..3) from the payload.
  function automatic logic [15:0] payload_word(input payload_t p, input logic [1:0] axis);
    logic [2:0] lo;
    lo = {axis, 1'b0};
    return {p[lo + 3'd1], p[lo]};
  endfunction

endpackage

// File: rtl/sensor_frame_parser_if.sv
// Byte stream from the UART receiver into the frame parser.
interface sensor_frame_parser_if;

  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);

endinterface

// File: rtl/sensor_frame_parser_gap_timer.sv
// Saturating idle counter: counts up to LIMIT and holds; clear restarts it
// from zero. PRESET_FULL makes it come out of reset already expired.
module gap_timer #(
  parameter int LIMIT       = 4096,
  parameter bit PRESET_FULL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam int             W       = $clog2(LIMIT + 1);
  localparam logic [W-1:0]   LIMIT_W = W'(LIMIT);

  logic [W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise step until the limit is reached.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != LIMIT_W) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, preset to full for timers that must start expired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= PRESET_FULL ? LIMIT_W : '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT_W);

endmodule

// File: rtl/sensor_frame_parser.sv
// Reassembles 11-byte sensor frames, verifies the checksum and publishes one
// accel axis and one angle axis, plus error pulses and link liveness.
module sensor_frame_parser
  import sensor_pkg::*;
#(
  parameter int ACCEL_AXIS   = 1,
  parameter int ANGLE_AXIS   = 2,
  parameter int BYTE_TIMEOUT = 4096,
  parameter int LINK_TIMEOUT = 2**20
) (
  input  logic                        clk_uart,
  input  logic                        rst_n,
  sensor_frame_parser_if.slave        rx,
  output logic [15:0]                 acceleration,
  output logic [15:0]                 direction,
  output logic                        accel_update,
  output logic                        dir_update,
  output logic                        frame_error,
  output logic [7:0]                  error_count,
  output logic                        link_alive
);

  parser_state_t state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    checksum_q, checksum_d;
  payload_t      payload_q, payload_d;
  logic          is_angle_q, is_angle_d;
  logic [15:0]   acceleration_q, acceleration_d;
  logic [15:0]   direction_q, direction_d;
  logic          accel_update_q, accel_update_d;
  logic          dir_update_q, dir_update_d;
  logic          frame_error_q, frame_error_d;
  logic [7:0]    error_count_q, error_count_d;

  logic          good_frame;
  logic          byte_expired;
  logic          link_expired;
  logic          byte_clear;

  // The gap timer only matters inside a frame; it is held at zero while
  // hunting and restarted by every byte or by its own expiry.
  assign byte_clear = rx.rx_valid || (state_q == HUNT) || byte_expired;

  gap_timer #(
    .LIMIT       (BYTE_TIMEOUT),
    .PRESET_FULL (1'b0)
  ) u_byte_timer (
    .clk     (clk_uart),
    .rst_n   (rst_n),
    .clear   (byte_clear),
    .expired (byte_expired)
  );

  gap_timer #(
    .LIMIT       (LINK_TIMEOUT),
    .PRESET_FULL (1'b1)
  ) u_link_timer (
    .clk     (clk_uart),
    .rst_n   (rst_n),
    .clear   (good_frame),
    .expired (link_expired)
  );

  // Frame state machine: byte handling has priority over the byte timeout.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    checksum_d     = checksum_q;
    payload_d      = payload_q;
    is_angle_d     = is_angle_q;
    acceleration_d = acceleration_q;
    direction_d    = direction_q;
    accel_update_d = 1'b0;
    dir_update_d   = 1'b0;
    frame_error_d  = 1'b0;
    good_frame     = 1'b0;

    if (rx.rx_valid) begin
      unique case (state_q)
        HUNT: begin
          if (rx.rx_data == FRAME_HEADER) begin
            checksum_d = FRAME_HEADER;
            state_d    = TYPE;
          end
        end
        TYPE: begin
          if (rx.rx_data == FRAME_HEADER) begin
            checksum_d = FRAME_HEADER;
          end else if (rx.rx_data == TYPE_ACCEL || rx.rx_data == TYPE_ANGLE) begin
            is_angle_d = (rx.rx_data == TYPE_ANGLE);
            checksum_d = checksum_q + rx.rx_data;
            idx_d      = 3'd0;
            state_d    = PAYLOAD;
          end else begin
            state_d = HUNT;
          end
        end
        PAYLOAD: begin
          payload_d[idx_q] = rx.rx_data;
          checksum_d       = checksum_q + rx.rx_data;
          idx_d            = idx_q + 3'd1;
          if (idx_q == 3'(PAYLOAD_BYTES - 1)) begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          state_d = HUNT;
          if (rx.rx_data == checksum_q) begin
            good_frame = 1'b1;
            if (is_angle_q) begin
              direction_d  = payload_word(payload_q, 2'(ANGLE_AXIS));
              dir_update_d = 1'b1;
            end else begin
              acceleration_d = payload_word(payload_q, 2'(ACCEL_AXIS));
              accel_update_d = 1'b1;
            end
          end else begin
            frame_error_d = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (byte_expired && state_q != HUNT) begin
      state_d       = HUNT;
      frame_error_d = 1'b1;
    end

    error_count_d = error_count_q;
    if (frame_error_d && error_count_q != 8'hFF) begin
      error_count_d = error_count_q + 8'd1;
    end
  end

  // Parser and output registers; reset drops any partial frame.
  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= HUNT;
      idx_q          <= 3'd0;
      checksum_q     <= 8'd0;
      payload_q      <= '0;
      is_angle_q     <= 1'b0;
      acceleration_q <= 16'd0;
      direction_q    <= 16'd0;
      accel_update_q <= 1'b0;
      dir_update_q   <= 1'b0;
      frame_error_q  <= 1'b0;
      error_count_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      checksum_q     <= checksum_d;
      payload_q      <= payload_d;
      is_angle_q     <= is_angle_d;
      acceleration_q <= acceleration_d;
      direction_q    <= direction_d;
      accel_update_q <= accel_update_d;
      dir_update_q   <= dir_update_d;
      frame_error_q  <= frame_error_d;
      error_count_q  <= error_count_d;
    end
  end

  assign acceleration = acceleration_q;
  assign direction    = direction_q;
  assign accel_update = accel_update_q;
  assign dir_update   = dir_update_q;
  assign frame_error  = frame_error_q;
  assign error_count  = error_count_q;
  assign link_alive   = ~link_expired;

endmodule
